// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Optional checksum stage is compiled in with IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int COUNT_W        = 8;
    localparam int WORD_W         = BYTES_PER_WORD * 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_DONE,
        ST_ERR
`ifdef IMEM_LOADER_CHECKSUM_EN
        , ST_CHK
`endif
    } loader_state_t;

    // States in which the byte stream is open.
    function automatic logic is_busy(input loader_state_t s);
        logic b;
        b = (s == ST_HDR) || (s == ST_DATA);
`ifdef IMEM_LOADER_CHECKSUM_EN
        b = b || (s == ST_CHK);
`endif
        return b;
    endfunction

endpackage

// File: rtl/imem_loader_packer.sv
// byte_packer: assembles little-endian bytes into words.
// Ports: clk, rst (async low), clr (sync), valid, byte_in -> word_o, word_done.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              valid,
    input  logic [7:0]        byte_in,
    output logic [WORD_W-1:0] word_o,
    output logic              word_done
);

    localparam int IDX_W = $clog2(BYTES_PER_WORD);

    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;

    // Bytes enter at the top and drift down, so the first byte
    // of a word lands in [7:0] once the word is complete.
    assign word_o    = {byte_in, shreg_q[WORD_W-1:8]};
    assign word_done = valid && (idx_q == IDX_W'(BYTES_PER_WORD - 1));

    always_comb begin
        idx_d   = idx_q;
        shreg_d = shreg_q;
        if (clr) begin
            idx_d   = '0;
            shreg_d = '0;
        end else if (valid) begin
            idx_d   = idx_q + 1'b1;
            shreg_d = word_o;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q   <= '0;
            shreg_q <= '0;
        end else begin
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: writes instruction memory from a byte stream, then starts the core.
// Ports: clk, rst (async low), load_req, in_valid/in_data/in_ready byte stream,
// im_we/im_addr/im_wdata memory write, cpu_start, busy, err.
// Macro IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 256,
    parameter bit AUTOSTART = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_req,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_start,
    output logic              busy,
    output logic              err
);

    // Word counter is one bit wider than the address so N=0 can mean DEPTH.
    localparam int CNT_W = ((ADDR_W > COUNT_W) ? ADDR_W : COUNT_W) + 1;
    localparam loader_state_t RST_STATE = AUTOSTART ? ST_DONE : ST_IDLE;

    loader_state_t      state_q, state_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [CNT_W-1:0]   wcnt_q, wcnt_d;
    logic               in_ready_q, in_ready_d;
    logic               im_we_q, im_we_d;
    logic [ADDR_W-1:0]  im_addr_q, im_addr_d;
    logic [31:0]        im_wdata_q, im_wdata_d;
    logic               cpu_start_q, cpu_start_d;
    logic               busy_q, busy_d;

    logic               accept;
    logic               pk_valid;
    logic               pk_clr;
    logic               pk_done;
    logic [WORD_W-1:0]  pk_word;
    logic [CNT_W-1:0]   words_total;
    logic               last_word;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;
    logic       err_q, err_d;
`endif

    assign accept      = in_valid && in_ready_q;
    assign words_total = (count_q == '0) ? CNT_W'(DEPTH) : CNT_W'(count_q);
    assign last_word   = (wcnt_q + CNT_W'(1)) == words_total;

    byte_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clr       (pk_clr),
        .valid     (pk_valid),
        .byte_in   (in_data),
        .word_o    (pk_word),
        .word_done (pk_done)
    );

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        addr_d     = addr_q;
        wcnt_d     = wcnt_q;
        im_we_d    = 1'b0;
        im_addr_d  = im_addr_q;
        im_wdata_d = im_wdata_q;
        pk_valid   = 1'b0;
        pk_clr     = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        // A restart wins over any byte arriving in the same cycle.
        if (load_req) begin
            state_d = ST_HDR;
            pk_clr  = 1'b1;
            addr_d  = '0;
            wcnt_d  = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_d  = '0;
`endif
        end else begin
            unique case (state_q)
                ST_HDR: begin
                    pk_clr = 1'b1;
                    if (accept) begin
                        count_d = in_data;
                        addr_d  = '0;
                        wcnt_d  = '0;
                        state_d = ST_DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_d  = '0;
`endif
                    end
                end
                ST_DATA: begin
                    if (accept) begin
                        pk_valid = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_d   = csum_q ^ in_data;
`endif
                        if (pk_done) begin
                            im_we_d    = 1'b1;
                            im_addr_d  = addr_q;
                            im_wdata_d = pk_word;
                            addr_d     = addr_q + 1'b1;
                            wcnt_d     = wcnt_q + 1'b1;
                            if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                state_d = ST_CHK;
`else
                                state_d = ST_DONE;
`endif
                            end
                        end
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                ST_CHK: begin
                    if (accept) begin
                        state_d = (in_data == csum_q) ? ST_DONE : ST_ERR;
                    end
                end
`endif
                default: ;
            endcase
        end

        busy_d     = is_busy(state_d);
        in_ready_d = busy_d;
        // Straight out of DATA the start is held back one cycle so it
        // never coincides with the final write pulse.
        cpu_start_d = (state_d == ST_DONE) && (state_q != ST_DATA);
`ifdef IMEM_LOADER_CHECKSUM_EN
        err_d       = (state_d == ST_ERR);
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RST_STATE;
            count_q     <= '0;
            addr_q      <= '0;
            wcnt_q      <= '0;
            in_ready_q  <= 1'b0;
            im_we_q     <= 1'b0;
            im_addr_q   <= '0;
            im_wdata_q  <= '0;
            cpu_start_q <= AUTOSTART;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            addr_q      <= addr_d;
            wcnt_q      <= wcnt_d;
            in_ready_q  <= in_ready_d;
            im_we_q     <= im_we_d;
            im_addr_q   <= im_addr_d;
            im_wdata_q  <= im_wdata_d;
            cpu_start_q <= cpu_start_d;
            busy_q      <= busy_d;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            csum_q <= '0;
            err_q  <= 1'b0;
        end else begin
            csum_q <= csum_d;
            err_q  <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign in_ready  = in_ready_q;
    assign im_we     = im_we_q;
    assign im_addr   = im_addr_q;
    assign im_wdata  = im_wdata_q;
    assign cpu_start = cpu_start_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader against a word-level loader model.
// Works with and without IMEM_LOADER_CHECKSUM_EN.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_req;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        im_we;
    logic [7:0]  im_addr;
    logic [31:0] im_wdata;
    logic        cpu_start;
    logic        busy;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;
    int we_cnt  = 0;
    logic prev_we = 1'b0;

    logic [31:0] dut_mem   [256];
    logic [31:0] model_mem [256];
    logic [7:0]  dir_q [$];

    always #5 clk = ~clk;

    imem_loader dut (
        .clk       (clk),
        .rst       (rst),
        .load_req  (load_req),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .im_we     (im_we),
        .im_addr   (im_addr),
        .im_wdata  (im_wdata),
        .cpu_start (cpu_start),
        .busy      (busy),
        .err       (err)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory-side observer: records writes and flags stretched pulses.
    always @(negedge clk) begin
        if (im_we) begin
            check("we_single", 32'(prev_we), 32'd0);
            we_cnt++;
            dut_mem[im_addr] = im_wdata;
        end
        prev_we = im_we;
    end

    function automatic logic [7:0] next_byte();
        if (dir_q.size() > 0) return dir_q.pop_front();
        return 8'($urandom);
    endfunction

    // Called at posedge+1; returns at posedge+1 after the byte is taken.
    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        while (!in_ready && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 20) check("rdy_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic pulse_load();
        load_req = 1'b1;
        @(posedge clk);
        #1;
        load_req = 1'b0;
    endtask

    task automatic run_session(input logic [7:0] n, input bit bad);
        int nw;
        int base;
        bit was_start;
        logic [7:0]  b;
        logic [7:0]  cs;
        logic [31:0] wd;
        was_start = cpu_start;
        pulse_load();
        if (was_start) check("start_drop", 32'(cpu_start), 32'd0);
        check("hdr_rdy", 32'(in_ready), 32'd1);
        check("err_clr", 32'(err), 32'd0);
        send_byte(n);
        nw   = (n == 0) ? 256 : int'(n);
        base = we_cnt;
        cs   = 8'h00;
        wd   = '0;
        for (int w = 0; w < nw; w++) begin
            for (int k = 0; k < 4; k++) begin
                b = next_byte();
                cs = cs ^ b;
                wd[8*k +: 8] = b;
                send_byte(b);
            end
            model_mem[w] = wd;
            check("we_at_t1", 32'(im_we), 32'd1);
            check("we_addr", 32'(im_addr), 32'(w));
            check("we_data", im_wdata, wd);
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(cs ^ {7'd0, bad});
        if (bad) begin
            check("chk_err", 32'(err), 32'd1);
            check("chk_err_start", 32'(cpu_start), 32'd0);
            check("chk_err_rdy", 32'(in_ready), 32'd0);
        end else begin
            check("chk_start", 32'(cpu_start), 32'd1);
            check("chk_ok_err", 32'(err), 32'd0);
        end
`else
        check("bad_unused", 32'(bad), 32'd0);
        check("start_t1", 32'(cpu_start), 32'd0);
        check("busy_t1", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check("start_t2", 32'(cpu_start), 32'd1);
        check("err_zero", 32'(err), 32'd0);
`endif
        // Bytes offered while the loader is closed must be ignored.
        in_valid = 1'b1;
        repeat (5) begin
            in_data = 8'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("write_count", 32'(we_cnt - base), 32'(nw));
    endtask

    initial begin
        int base;
        logic [7:0]  b;
        logic [7:0]  cs;
        logic [31:0] wd;

        rst      = 1'b0;
        load_req = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        #3;
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_we", 32'(im_we), 32'd0);
        check("rst_addr", 32'(im_addr), 32'd0);
        check("rst_wdata", im_wdata, 32'd0);
        check("rst_start", 32'(cpu_start), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        in_valid = 1'b1;
        in_data  = 8'hA5;
        repeat (4) @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("idle_no_we", 32'(we_cnt), 32'd0);
        check("idle_rdy", 32'(in_ready), 32'd0);

        dir_q = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        run_session(8'd2, 1'b0);
        check("dir_w0", dut_mem[0], 32'h12345678);
        check("dir_w1", dut_mem[1], 32'hDEADBEEF);

`ifdef IMEM_LOADER_CHECKSUM_EN
        dir_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_session(8'd1, 1'b0);
        dir_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_session(8'd1, 1'b1);
`endif

        repeat (6) run_session(8'($urandom_range(1, 12)), 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        run_session(8'($urandom_range(1, 12)), 1'b1);
`endif

        run_session(8'd0, 1'b0);
        check("full_w0", dut_mem[0], model_mem[0]);
        check("full_w255", dut_mem[255], model_mem[255]);

        // Abort after six data bytes, with a byte colliding with load_req.
        pulse_load();
        base = we_cnt;
        send_byte(8'd3);
        wd = '0;
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom);
            wd[8*(i%4) +: 8] = b;
            send_byte(b);
            if (i == 3) begin
                check("ab_we", 32'(im_we), 32'd1);
                check("ab_addr0", 32'(im_addr), 32'd0);
                check("ab_w0", im_wdata, wd);
            end
        end
        in_valid = 1'b1;
        in_data  = 8'h5A;
        load_req = 1'b1;
        @(posedge clk);
        #1;
        load_req = 1'b0;
        in_valid = 1'b0;
        check("ab_hdr_rdy", 32'(in_ready), 32'd1);
        check("ab_busy", 32'(busy), 32'd1);
        check("ab_writes", 32'(we_cnt - base), 32'd1);
        send_byte(8'd1);
        cs = 8'h00;
        for (int k = 0; k < 4; k++) begin
            b = 8'($urandom);
            cs = cs ^ b;
            wd[8*k +: 8] = b;
            send_byte(b);
        end
        check("ab_re_we", 32'(im_we), 32'd1);
        check("ab_re_addr", 32'(im_addr), 32'd0);
        check("ab_re_data", im_wdata, wd);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(cs);
`else
        check("ab_cs_unused", 32'(cs ^ cs), 32'd0);
`endif
        repeat (2) @(posedge clk);
        #1;
        check("ab_done", 32'(cpu_start), 32'd1);

        // Asynchronous reset in the middle of DATA.
        pulse_load();
        send_byte(8'd4);
        send_byte(8'h01);
        send_byte(8'h02);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_rdy", 32'(in_ready), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_start", 32'(cpu_start), 32'd0);
        check("mid_rst_we", 32'(im_we), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("post_rst_idle", 32'(in_ready), 32'd0);
        run_session(8'd3, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
